// File: rtl/btb_update_sched.sv
// rtl/btb_update_sched.sv - BTB write-port scheduler: update FIFO drain and invalidation sweep (optional BTB_UPD_COALESCE_EN)
module btb_update_sched #(
    parameter int NUM_BTB_ENTRIES = 8,
    parameter int FIFO_DEPTH      = 4,
    localparam int LOG2_BTB       = $clog2(NUM_BTB_ENTRIES),
    localparam int TAG_W          = 30 - LOG2_BTB,
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_ni,
    input  logic                upd_valid_i,
    output logic                upd_ready_o,
    input  logic [31:0]         upd_pc_i,
    input  logic [31:0]         upd_target_i,
    input  logic                upd_j_i,
    input  logic                upd_b_i,
    input  logic                flush_req_i,
    input  logic                wr_hold_i,
    output logic                wr_en_o,
    output logic [LOG2_BTB-1:0] wr_index_o,
    output logic [TAG_W-1:0]    wr_tag_o,
    output logic [31:0]         wr_target_o,
    output logic                wr_j_o,
    output logic                wr_b_o,
    output logic                flush_busy_o,
    output logic [CNT_W-1:0]    occupancy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LOG2_BTB-1:0] LAST_IDX = LOG2_BTB'(NUM_BTB_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Word-aligned PC only; the byte offset never reaches the BTB.
    logic [29:0] pc_mem_q     [FIFO_DEPTH];
    logic [31:0] target_mem_q [FIFO_DEPTH];
    logic        j_mem_q      [FIFO_DEPTH];
    logic        b_mem_q      [FIFO_DEPTH];

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LOG2_BTB-1:0] flush_cnt_q, flush_cnt_d;

    logic             full;
    logic             empty;
    logic             pop;
    logic             accept;
    logic             keep;
    logic             coalesce;
    logic             push_new;
    logic             flush_start;
    logic             ready_room;
    logic [PTR_W-1:0] wr_addr;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^upd_pc_i[1:0];

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign pop         = (state_q == DRAIN) && !wr_hold_i;
    assign flush_start = flush_req_i && (state_q != FLUSH);

`ifdef BTB_UPD_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr;
    logic             tail_match;

    assign tail_ptr   = wr_ptr_q - PTR_W'(1);
    assign tail_match = !empty &&
                        (pc_mem_q[tail_ptr][LOG2_BTB-1:0] == upd_pc_i[LOG2_BTB+1:2]);
    // A lone entry leaving this cycle cannot be rewritten, so the update takes a fresh slot.
    assign coalesce   = keep && tail_match && !(pop && (count_q == CNT_W'(1)));
    assign ready_room = !full || tail_match;
    assign wr_addr    = coalesce ? tail_ptr : wr_ptr_q;
`else
    assign coalesce   = 1'b0;
    assign ready_room = !full;
    assign wr_addr    = wr_ptr_q;
`endif

    assign upd_ready_o = ready_room && (state_q != FLUSH) && !flush_req_i;
    assign accept      = upd_valid_i && upd_ready_o;
    // Neither jump nor branch: handshake completes but nothing is stored.
    assign keep        = accept && (upd_j_i || upd_b_i);
    assign push_new    = keep && !coalesce;

    assign occupancy_o = count_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN simply mirrors a non-empty queue outside a sweep.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FLUSH: begin
                if (!wr_hold_i && (flush_cnt_q == LAST_IDX)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (flush_req_i) begin
                    state_d = FLUSH;
                end else if (count_d != '0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Output logic: write port driven purely from registered state.
    always_comb begin
        wr_en_o      = 1'b0;
        wr_index_o   = '0;
        wr_tag_o     = '0;
        wr_target_o  = '0;
        wr_j_o       = 1'b0;
        wr_b_o       = 1'b0;
        flush_busy_o = 1'b0;
        case (state_q)
            DRAIN: begin
                wr_en_o     = !wr_hold_i;
                wr_index_o  = pc_mem_q[rd_ptr_q][LOG2_BTB-1:0];
                wr_tag_o    = pc_mem_q[rd_ptr_q][29:LOG2_BTB];
                wr_target_o = target_mem_q[rd_ptr_q];
                wr_j_o      = j_mem_q[rd_ptr_q];
                wr_b_o      = b_mem_q[rd_ptr_q];
            end
            FLUSH: begin
                flush_busy_o = 1'b1;
                wr_en_o      = !wr_hold_i;
                wr_index_o   = flush_cnt_q;
            end
            default: begin
            end
        endcase
    end

    // Queue pointer and occupancy bookkeeping; a starting sweep discards everything queued.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_start) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_new) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_new) - CNT_W'(pop);
        end
    end

    // Sweep index advances only on cycles the write port actually fires.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush_start) begin
            flush_cnt_d = '0;
        end else if ((state_q == FLUSH) && !wr_hold_i) begin
            flush_cnt_d = (flush_cnt_q == LAST_IDX) ? '0 : flush_cnt_q + LOG2_BTB'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Queue storage; contents are only observed while the count says they are valid.
    always_ff @(posedge clk) begin
        if (keep) begin
            pc_mem_q[wr_addr]     <= upd_pc_i[31:2];
            target_mem_q[wr_addr] <= upd_target_i;
            j_mem_q[wr_addr]      <= upd_j_i;
            b_mem_q[wr_addr]      <= upd_b_i;
        end
    end

endmodule

// File: tb/tb_btb_update_sched.sv
// tb/tb_btb_update_sched.sv - scoreboard bench for btb_update_sched
module tb_btb_update_sched;

    logic        clk;
    logic        reset_ni;
    logic        upd_valid_i;
    logic        upd_ready_o;
    logic [31:0] upd_pc_i;
    logic [31:0] upd_target_i;
    logic        upd_j_i;
    logic        upd_b_i;
    logic        flush_req_i;
    logic        wr_hold_i;
    logic        wr_en_o;
    logic [2:0]  wr_index_o;
    logic [26:0] wr_tag_o;
    logic [31:0] wr_target_o;
    logic        wr_j_o;
    logic        wr_b_o;
    logic        flush_busy_o;
    logic [2:0]  occupancy_o;

    typedef struct packed {
        logic [2:0]  idx;
        logic [26:0] tag;
        logic [31:0] tgt;
        logic        j;
        logic        b;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    btb_update_sched #(
        .NUM_BTB_ENTRIES(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_ni(reset_ni),
        .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_o),
        .upd_pc_i(upd_pc_i),
        .upd_target_i(upd_target_i),
        .upd_j_i(upd_j_i),
        .upd_b_i(upd_b_i),
        .flush_req_i(flush_req_i),
        .wr_hold_i(wr_hold_i),
        .wr_en_o(wr_en_o),
        .wr_index_o(wr_index_o),
        .wr_tag_o(wr_tag_o),
        .wr_target_o(wr_target_o),
        .wr_j_o(wr_j_o),
        .wr_b_o(wr_b_o),
        .flush_busy_o(flush_busy_o),
        .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic [26:0] tag,
                            input logic [31:0] tgt, input logic j, input logic b);
        wr_t e;
        e.idx = idx;
        e.tag = tag;
        e.tgt = tgt;
        e.j   = j;
        e.b   = b;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 8; i++) push_exp(3'(i), 27'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic j, input logic b);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_target_i = tgt;
        upd_j_i      = j;
        upd_b_i      = b;
    endtask

    // Monitor: every write-port strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_ni && wr_en_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got idx=%0d tag=0x%0h tgt=0x%0h j=%0b b=%0b expected none",
                         wr_index_o, wr_tag_o, wr_target_o, wr_j_o, wr_b_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_index_o !== e.idx || wr_tag_o !== e.tag || wr_target_o !== e.tgt ||
                    wr_j_o !== e.j || wr_b_o !== e.b) begin
                    n_fail++;
                    $display("FAIL write_data: got idx=%0d tag=0x%0h tgt=0x%0h j=%0b b=%0b expected idx=%0d tag=0x%0h tgt=0x%0h j=%0b b=%0b",
                             wr_index_o, wr_tag_o, wr_target_o, wr_j_o, wr_b_o,
                             e.idx, e.tag, e.tgt, e.j, e.b);
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        int pulse_cnt;

        reset_ni    = 1'b0;
        flush_req_i = 1'b0;
        wr_hold_i   = 1'b0;
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) step();
        reset_ni = 1'b1;
        @(negedge clk);
        chk("reset_occupancy", 32'(occupancy_o), 32'd0);
        chk("reset_busy", 32'(flush_busy_o), 32'd0);
        chk("reset_wr_en", 32'(wr_en_o), 32'd0);
        chk("reset_ready", 32'(upd_ready_o), 32'd1);
        chk("reset_index", 32'(wr_index_o), 32'd0);
        chk("reset_target", wr_target_o, 32'd0);

        // Single update with minimum latency.
        step();
        drive_upd(1'b1, 32'h0000_0104, 32'h0000_0200, 1'b0, 1'b1);
        push_exp(3'd1, 27'h8, 32'h200, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_ready", 32'(upd_ready_o), 32'd1);
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_wr_en", 32'(wr_en_o), 32'd1);
        chk("t1_occ_one", 32'(occupancy_o), 32'd1);
        step();
        @(negedge clk);
        chk("t1_occ_zero", 32'(occupancy_o), 32'd0);
        chk("t1_wr_en_low", 32'(wr_en_o), 32'd0);

        // Neither J nor B: accepted, never stored.
        step();
        drive_upd(1'b1, 32'h0000_0300, 32'h0000_0999, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_ready", 32'(upd_ready_o), 32'd1);
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_occ", 32'(occupancy_o), 32'd0);

        // Held port, five offers: four fit, fifth refused.
        step();
        wr_hold_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            drive_upd(1'b1, 32'h1000 + 32'(4 * k), 32'h2000 + 32'(16 * k), k[0], !k[0]);
            if (k < 4) push_exp(3'(k), 27'h80, 32'h2000 + 32'(16 * k), k[0], !k[0]);
            @(negedge clk);
            chk($sformatf("t2_ready_%0d", k), 32'(upd_ready_o), (k < 4) ? 32'd1 : 32'd0);
        end
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_occ_full", 32'(occupancy_o), 32'd4);
        step();
        wr_hold_i = 1'b0;
        for (int q = 0; q < 4; q++) begin
            if (q > 0) step();
            @(negedge clk);
            chk($sformatf("t2_drain_%0d", q), 32'(wr_en_o), 32'd1);
        end
        step();
        @(negedge clk);
        chk("t2_occ_empty", 32'(occupancy_o), 32'd0);

        // Flush with three queued entries discards them and sweeps 0..7.
        for (int k = 0; k < 3; k++) begin
            step();
            wr_hold_i = 1'b1;
            drive_upd(1'b1, 32'h2000 + 32'(4 * k), 32'h5555, 1'b1, 1'b0);
        end
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        flush_req_i = 1'b1;
        @(negedge clk);
        chk("t3_ready_on_req", 32'(upd_ready_o), 32'd0);
        chk("t3_occ_before", 32'(occupancy_o), 32'd3);
        push_sweep();
        step();
        flush_req_i = 1'b0;
        wr_hold_i   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk($sformatf("t3_busy_%0d", i), 32'(flush_busy_o), 32'd1);
            chk($sformatf("t3_ready_%0d", i), 32'(upd_ready_o), 32'd0);
            chk($sformatf("t3_wr_en_%0d", i), 32'(wr_en_o), 32'd1);
        end
        step();
        @(negedge clk);
        chk("t3_busy_end", 32'(flush_busy_o), 32'd0);
        chk("t3_occ_end", 32'(occupancy_o), 32'd0);
        chk("t3_ready_end", 32'(upd_ready_o), 32'd1);

        // Sweep with hold toggling every other cycle.
        step();
        flush_req_i = 1'b1;
        push_sweep();
        busy_cnt  = 0;
        pulse_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            flush_req_i = 1'b0;
            wr_hold_i   = (i % 2 == 0);
            @(negedge clk);
            if (flush_busy_o) busy_cnt++;
            if (wr_en_o) pulse_cnt++;
        end
        wr_hold_i = 1'b0;
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("t4_pulses", 32'(pulse_cnt), 32'd8);

        // Flush and update together; repeated flush mid-sweep ignored.
        step();
        flush_req_i = 1'b1;
        drive_upd(1'b1, 32'h0000_3004, 32'h0000_7000, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_ready_collide", 32'(upd_ready_o), 32'd0);
        push_sweep();
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            flush_req_i = (i == 3);
            @(negedge clk);
            if (flush_busy_o) busy_cnt++;
        end
        chk("t5_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("t5_occ", 32'(occupancy_o), 32'd0);

        // Reset while entries are queued loses them.
        step();
        wr_hold_i = 1'b1;
        drive_upd(1'b1, 32'h0000_4000, 32'h1, 1'b1, 1'b0);
        step();
        drive_upd(1'b1, 32'h0000_4004, 32'h2, 1'b0, 1'b1);
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset_ni = 1'b0;
        step();
        reset_ni  = 1'b1;
        wr_hold_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_occ", 32'(occupancy_o), 32'd0);
        chk("rst_mid_wr_en", 32'(wr_en_o), 32'd0);
        repeat (4) step();

`ifdef BTB_UPD_COALESCE_EN
        // Two updates to one index while held merge into one write.
        step();
        wr_hold_i = 1'b1;
        drive_upd(1'b1, 32'h0000_0010, 32'h0000_0040, 1'b1, 1'b0);
        step();
        drive_upd(1'b1, 32'h0000_0010, 32'h0000_0080, 1'b1, 1'b0);
        @(negedge clk);
        chk("co_ready", 32'(upd_ready_o), 32'd1);
        step();
        drive_upd(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("co_occ", 32'(occupancy_o), 32'd1);
        push_exp(3'd4, 27'd0, 32'h80, 1'b1, 1'b0);
        step();
        wr_hold_i = 1'b0;
        @(negedge clk);
        chk("co_wr_en", 32'(wr_en_o), 32'd1);
        step();
        @(negedge clk);
        chk("co_occ_empty", 32'(occupancy_o), 32'd0);
        chk("co_wr_en_low", 32'(wr_en_o), 32'd0);
`endif

        repeat (4) step();
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_update_sched.md
Name: btb_update_sched

Overview:
- Schedules all writes into the single BTB write port.
- Buffers E-stage BTB update requests from branch/jump resolution in a small FIFO and drains them one per cycle.
- Runs a full-table invalidation sweep on request, e.g. on context switch or self-modifying-code fence.
- Sits between the execute-stage resolution logic and the BTB storage array; converts PCs into index and tag fields.

Parameters:
- NUM_BTB_ENTRIES, 8, number of BTB entries; power of 2, minimum 2.
- FIFO_DEPTH, 4, update queue depth; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- upd_valid_i  input  1  update request valid (E stage).
- upd_ready_o  output  1  scheduler can accept an update this cycle.
- upd_pc_i  input  32  PC of the resolved jump or branch.
- upd_target_i  input  32  resolved branch target address.
- upd_j_i  input  1  entry is a jump.
- upd_b_i  input  1  entry is a conditional branch.
- flush_req_i  input  1  single-cycle pulse requesting full invalidation.
- wr_hold_i  input  1  BTB write port blocked this cycle.
- wr_en_o  output  1  BTB write strobe.
- wr_index_o  output  LOG2_BTB  entry index, pc[LOG2_BTB+1:2].
- wr_tag_o  output  30-LOG2_BTB  entry tag, pc[31:LOG2_BTB+2].
- wr_target_o  output  32  entry target.
- wr_j_o  output  1  entry J bit.
- wr_b_o  output  1  entry B bit.
- flush_busy_o  output  1  invalidation sweep in progress.
- occupancy_o  output  $clog2(FIFO_DEPTH)+1  number of queued updates.

Behaviour:
- LOG2_BTB = $clog2(NUM_BTB_ENTRIES).
- FIFO is circular with read/write pointers and a count; pointers wrap modulo FIFO_DEPTH.
- Reset (reset_ni low at a clock edge):
  - state IDLE; FIFO empty; flush counter 0.
  - occupancy_o 0, flush_busy_o 0, wr_en_o 0; all wr_* data outputs 0.
  - upd_ready_o is 1 in the first cycle after reset unless flush_req_i is high.
  - Reset mid-sweep or mid-drain aborts immediately; queued entries are lost.
- upd_ready_o = !full && state!=FLUSH && !flush_req_i (combinational).
  - Full is evaluated before any same-cycle pop, so no enqueue is accepted when count==FIFO_DEPTH even if a pop occurs.
- Enqueue: on upd_valid_i && upd_ready_o, store {pc, target, j, b} at the write pointer.
- Entries with upd_j_i==0 and upd_b_i==0 are accepted but dropped: not stored, count unchanged.
- States:
  - IDLE: FIFO empty, no sweep.
  - DRAIN: FIFO non-empty.
  - FLUSH: sweep active.
- Transitions:
  - flush_req_i high in IDLE or DRAIN → FLUSH next cycle. The FIFO is cleared (count 0) and the flush counter is set to 0.
  - FLUSH → IDLE after the write to index NUM_BTB_ENTRIES-1 completes.
  - IDLE → DRAIN when an enqueue occurs.
  - DRAIN → IDLE when the last entry is popped and no enqueue occurs in the same cycle.
- DRAIN output and pop:
  - wr_en_o = !wr_hold_i.
  - wr_* carry the FIFO head; index and tag are sliced from the stored PC.
  - Pop happens when wr_en_o is 1.
  - wr_en_o is driven from registered FIFO state only, never combinationally from upd_*.
  - Minimum latency: update accepted at edge N appears on wr_en_o in the cycle after edge N.
- Simultaneous push and pop: allowed when not full; count unchanged; order preserved, strict FIFO.
- FLUSH:
  - flush_busy_o 1.
  - wr_en_o = !wr_hold_i; wr_index_o = counter; tag, target, J and B all 0.
  - Counter increments only when wr_en_o is 1 and wraps to 0 on exit.
  - flush_req_i during FLUSH is ignored; the sweep is not restarted.
- Sweep length: NUM_BTB_ENTRIES write cycles plus held cycles.
- wr_hold_i freezes pops and the counter. All outputs stay stable while held, except that wr_en_o is 0.

Optional Feature:
- Macro: BTB_UPD_COALESCE_EN.
- Defined:
  - Coalescing: if an accepted update has the same index as the most recently enqueued entry that is still queued, overwrite that entry in place. Count is unchanged.
  - Exception: if that entry is the head and is being popped in the same cycle, enqueue normally.
  - Coalescing is allowed when full: upd_ready_o is asserted when full if upd_pc_i index matches the tail entry.
- Undefined: every accepted update occupies its own slot.

Test Plan:
- Reset, then an update with pc=0x0000_0104, target=0x0000_0200, b=1 → next cycle wr_en_o=1, wr_index_o=1, wr_tag_o=0x0000008, wr_target_o=0x200, wr_b_o=1; occupancy_o returns 0.
- wr_hold_i=1, then 5 back-to-back updates → 4 accepted, upd_ready_o=0 on the 5th, occupancy_o=4. Release hold → 4 writes on consecutive cycles, in order.
- flush_req_i pulse with 3 queued entries → FIFO cleared; 8 writes to indices 0..7 with all fields 0; flush_busy_o high 8 cycles; upd_ready_o=0 throughout.
- wr_hold_i toggled every other cycle during a sweep → exactly 8 wr_en_o pulses, indices contiguous 0..7, sweep lasts 16 cycles.
- flush_req_i and upd_valid_i in the same cycle → upd_ready_o=0, update not enqueued. Second flush_req_i mid-sweep → ignored; sweep ends after index 7.
- With BTB_UPD_COALESCE_EN, wr_hold_i=1 and two updates to pc 0x10 (target 0x40, then 0x80) → occupancy_o=1; after release, a single write with wr_target_o=0x80.
